// File: rtl/reaction_pkg.sv
// rtl/reaction_pkg.sv - shared encodings and defaults for the reaction game core
// Purpose: round-phase and difficulty encodings plus default timing constants
//          used by reaction_core and score_meter.
package reaction_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_COUNT = 2'd2,
        ST_SCORE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        MODE_SLOW   = 2'd0,
        MODE_MEDIUM = 2'd1,
        MODE_FAST   = 2'd2,
        MODE_TURBO  = 2'd3
    } mode_e;

    localparam int DEF_TICKS_0    = 1000000;
    localparam int DEF_TICKS_1    = 200000;
    localparam int DEF_TICKS_2    = 100000;
    localparam int DEF_TICKS_3    = 50000;
    localparam int DEF_SCORE_STEP = 30;

endpackage

// File: rtl/score_meter.sv
// rtl/score_meter.sv - iterative |number-target| scorer driving the LED bar
// Purpose: on i_start registers diff = |i_number - i_target|, then removes
//          SCORE_STEP per cycle counting q, and finally shows all-ones << q.
// Ports:   i_clk, i_rst_n    clock, async active-low reset
//          i_start           one-cycle pulse, first SCORE cycle
//          i_clear           clears the LED bar when the round ends
//          i_number/i_target values to compare
//          o_led             score bar, valid from o_done onward
//          o_diff            registered difference
//          o_done            one-cycle pulse when o_led updates
//          o_fin             high in the cycle whose edge produces o_done
module score_meter
    import reaction_pkg::*;
#(
    parameter int NUM_W      = 14,
    parameter int LED_N      = 16,
    parameter int SCORE_STEP = DEF_SCORE_STEP
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_clear,
    input  logic [NUM_W-1:0] i_number,
    input  logic [NUM_W-1:0] i_target,
    output logic [LED_N-1:0] o_led,
    output logic [NUM_W-1:0] o_diff,
    output logic             o_done,
    output logic             o_fin
);

    localparam int Q_W = $clog2(LED_N + 1);
    localparam logic [NUM_W-1:0] STEP_V  = NUM_W'(SCORE_STEP);
    localparam logic [Q_W-1:0]   LED_N_V = Q_W'(LED_N);

    logic [NUM_W-1:0] r_diff;
    logic [NUM_W-1:0] r_rem;
    logic [Q_W-1:0]   r_q;
    logic             r_busy;
    logic [LED_N-1:0] r_led;
    logic             r_done;

    logic [NUM_W-1:0] w_diff;
    logic             w_step_ok;

    // Larger minus smaller so the difference never wraps.
    assign w_diff    = (i_number >= i_target) ? (i_number - i_target) : (i_target - i_number);
    assign w_step_ok = (r_rem >= STEP_V) && (r_q < LED_N_V);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_diff <= '0;
            r_rem  <= '0;
            r_q    <= '0;
            r_busy <= 1'b0;
            r_led  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_clear) begin
                r_led <= '0;
            end
            if (i_start) begin
                r_diff <= w_diff;
                r_rem  <= w_diff;
                r_q    <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                if (w_step_ok) begin
                    r_rem <= r_rem - STEP_V;
                    r_q   <= r_q + Q_W'(1);
                end else begin
                    // q == LED_N shifts every one out, leaving an empty bar.
                    r_led  <= {LED_N{1'b1}} << r_q;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
            end
        end
    end

    assign o_led  = r_led;
    assign o_diff = r_diff;
    assign o_done = r_done;
    assign o_fin  = r_busy && !w_step_ok && !i_start;

endmodule

// File: rtl/reaction_core.sv
// rtl/reaction_core.sv - reaction game round sequencer with scoring and best tracking
// Purpose: mode select, target display, timed count-up and scoring of one round.
// Ports:   i_clk, i_rst_n                clock, async active-low reset
//          i_btn_up/i_btn_down/i_btn_sel debounced button levels
//          i_rand                        free-running random value
//          o_state                       round phase (IDLE/SHOW/COUNT/SCORE)
//          o_mode                        current difficulty
//          o_number                      displayed value
//          o_led                         score bar
//          o_best                        smallest difference since reset
//          o_done                        one-cycle pulse when o_led is valid
module reaction_core
    import reaction_pkg::*;
#(
    parameter int NUM_W      = 14,
    parameter int LED_N      = 16,
    parameter int MODES      = 3,
    parameter int MODE_RST   = 1,
    parameter int TICK_W     = 20,
    parameter int TICKS_0    = DEF_TICKS_0,
    parameter int TICKS_1    = DEF_TICKS_1,
    parameter int TICKS_2    = DEF_TICKS_2,
    parameter int TICKS_3    = DEF_TICKS_3,
    parameter int MAX_COUNT  = 9999,
    parameter int SCORE_STEP = DEF_SCORE_STEP
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_btn_up,
    input  logic             i_btn_down,
    input  logic             i_btn_sel,
    input  logic [NUM_W-1:0] i_rand,
    output logic [1:0]       o_state,
    output logic [1:0]       o_mode,
    output logic [NUM_W-1:0] o_number,
    output logic [LED_N-1:0] o_led,
    output logic [NUM_W-1:0] o_best,
    output logic             o_done
);

    localparam logic [NUM_W-1:0] MAX_V      = NUM_W'(MAX_COUNT);
    localparam logic [1:0]       MODE_TOP_V = 2'(MODES - 1);

    state_e           r_state;
    state_e           w_next_state;
    logic [1:0]       r_mode;
    logic [NUM_W-1:0] r_number;
    logic [NUM_W-1:0] r_target;
    logic [TICK_W-1:0] r_tick;
    logic [NUM_W-1:0] r_best;
    logic             r_up_q, r_dn_q, r_sel_q;
    logic             r_arm;
    logic             r_start;
    logic             r_scored;

    logic             w_up_rise, w_dn_rise, w_sel_rise;
    logic             w_at_max;
    logic             w_enter_score;
    logic             w_scored;
    logic             w_clear;
    logic [NUM_W-1:0] w_clamp;
    logic [TICK_W-1:0] w_tick_last;
    logic [NUM_W-1:0] w_diff;
    logic             w_done;
    logic             w_fin;

    function automatic logic [TICK_W-1:0] tick_last(input logic [1:0] m);
        case (m)
            2'd0:    tick_last = TICK_W'(TICKS_0 - 1);
            2'd1:    tick_last = TICK_W'(TICKS_1 - 1);
            2'd2:    tick_last = TICK_W'(TICKS_2 - 1);
            default: tick_last = TICK_W'(TICKS_3 - 1);
        endcase
    endfunction

    // r_arm masks the first edge after reset so a button held through
    // release never registers as a rise.
    assign w_up_rise  = r_arm && i_btn_up   && !r_up_q;
    assign w_dn_rise  = r_arm && i_btn_down && !r_dn_q;
    assign w_sel_rise = r_arm && i_btn_sel  && !r_sel_q;

    assign w_clamp     = (i_rand == '0) ? NUM_W'(1) : ((i_rand > MAX_V) ? MAX_V : i_rand);
    assign w_tick_last = tick_last(r_mode);
    assign w_at_max    = (r_number == MAX_V);
    // The done cycle itself already counts as "after done".
    assign w_scored    = r_scored || w_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_sel_rise) w_next_state = ST_SHOW;
            ST_SHOW:  if (w_sel_rise) w_next_state = ST_COUNT;
            ST_COUNT: if (w_sel_rise || w_at_max) w_next_state = ST_SCORE;
            ST_SCORE: if (w_sel_rise && w_scored) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    assign w_enter_score = (r_state == ST_COUNT) && (w_next_state == ST_SCORE);
    assign w_clear       = (r_state == ST_SCORE) && (w_next_state == ST_IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode   <= 2'(MODE_RST);
            r_number <= '0;
            r_target <= '0;
            r_tick   <= '0;
            r_best   <= '1;
            r_up_q   <= 1'b0;
            r_dn_q   <= 1'b0;
            r_sel_q  <= 1'b0;
            r_arm    <= 1'b0;
            r_start  <= 1'b0;
            r_scored <= 1'b0;
        end else begin
            r_up_q  <= i_btn_up;
            r_dn_q  <= i_btn_down;
            r_sel_q <= i_btn_sel;
            r_arm   <= 1'b1;
            r_start <= w_enter_score;

            if (w_enter_score) begin
                r_scored <= 1'b0;
            end else if (w_done) begin
                r_scored <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_up_rise && !w_dn_rise && r_mode != MODE_TOP_V) begin
                        r_mode <= r_mode + 2'd1;
                    end else if (w_dn_rise && !w_up_rise && r_mode != 2'd0) begin
                        r_mode <= r_mode - 2'd1;
                    end
                    if (w_sel_rise) begin
                        r_target <= w_clamp;
                        r_number <= w_clamp;
                    end
                end
                ST_SHOW: begin
                    if (w_sel_rise) begin
                        r_number <= '0;
                        r_tick   <= '0;
                    end
                end
                ST_COUNT: begin
                    // Leaving for SCORE freezes number and tick.
                    if (!w_enter_score) begin
                        if (r_tick == w_tick_last) begin
                            r_number <= r_number + NUM_W'(1);
                            r_tick   <= '0;
                        end else begin
                            r_tick <= r_tick + TICK_W'(1);
                        end
                    end
                end
                default: ;
            endcase

            if (w_fin && (w_diff < r_best)) begin
                r_best <= w_diff;
            end
        end
    end

    score_meter #(
        .NUM_W      (NUM_W),
        .LED_N      (LED_N),
        .SCORE_STEP (SCORE_STEP)
    ) u_score_meter (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_start  (r_start),
        .i_clear  (w_clear),
        .i_number (r_number),
        .i_target (r_target),
        .o_led    (o_led),
        .o_diff   (w_diff),
        .o_done   (w_done),
        .o_fin    (w_fin)
    );

    assign o_state  = r_state;
    assign o_mode   = r_mode;
    assign o_number = r_number;
    assign o_best   = r_best;
    assign o_done   = w_done;

endmodule
